hazard_sequencer: RTL
=====================

HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 The module SHALL have a parameter STALL_CNT_W, default 16, giving the width of the saturating stall-cycle counter.
REQ-002 The module SHALL have the port `clk`, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 The module SHALL have the port `reset`, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have the ports `id_rs1_i` and `id_rs2_i`, input, 5 bits each: source registers of the instruction in ID.
REQ-005 The module SHALL have the ports `id_rs1_used_i` and `id_rs2_used_i`, input, 1 bit each: the ID instruction reads that source.
REQ-006 The module SHALL have the ports `id_rd_i` (input, 5 bits) and `id_reg_write_i` (input, 1 bit): destination and write-enable of the ID instruction.
REQ-007 The module SHALL have the port `mem_redirect_i`, input, 1 bit: a taken branch or jalr is in MEM, and the PC mux selects the target.
REQ-008 The module SHALL have the port `pc_write_o`, output, 1 bit: the PC register may load.
REQ-009 The module SHALL have the port `if_id_write_o`, output, 1 bit: IF/ID may load.
REQ-010 The module SHALL have the ports `if_id_flush_o`, `id_ex_flush_o` and `ex_mem_flush_o`, output, 1 bit each: load a bubble (all control zero) into that pipe register.
REQ-011 The module SHALL have the port `state_o`, output, 2 bits: current sequencer state.
REQ-012 The module SHALL have the port `stall_count_o`, output, STALL_CNT_W bits: total stall cycles since reset.

Function
REQ-013 The module SHALL contain a three-entry scoreboard (EX, MEM, WB), each entry holding a valid bit, rd[4:0] and reg_write, mirroring the ID/EX, EX/MEM and MEM/WB registers.
REQ-014 A hazard SHALL exist when the ID entry is valid and, for any used source with rs != 0, some scoreboard entry has valid=1, reg_write=1 and rd equal to that rs.
REQ-015 Register 0 SHALL never cause a hazard, and unused sources SHALL be ignored.
REQ-016 The FSM states SHALL be RUN=0, STALL=1, FLUSH=2; encoding 3 is unused and SHALL return to RUN.
REQ-017 RUN: all outputs SHALL be pc_write=1, if_id_write=1 and all flushes=0 unless a hazard or redirect is present.
REQ-018 Hazard without redirect: pc_write=0, if_id_write=0, id_ex_flush=1 in the same cycle, and the next state SHALL be STALL.
REQ-019 STALL SHALL hold the same outputs while the hazard persists, and SHALL return to RUN in the first cycle in which the hazard is absent.
REQ-020 Stall length SHALL be 3/2/1 cycles for a producer in EX/MEM/WB, because the register file writes at the clock edge and reads combinationally, with no forwarding.
REQ-021 Redirect SHALL have priority over hazard in any state: pc_write=1, if_id_write=1, and all three flushes=1 in that cycle; the next state SHALL be FLUSH.
REQ-022 FLUSH SHALL last exactly one cycle: the ID entry is invalid (bubble), no hazard check, RUN outputs; the next state is RUN, or FLUSH again if mem_redirect_i=1.
REQ-023 Scoreboard update per edge SHALL be WB<=MEM.
REQ-024 Scoreboard update per edge: MEM<=EX, or an invalid entry if redirect.
REQ-025 Scoreboard update per edge: EX<=ID entry, or an invalid entry if stall or redirect.
REQ-026 The ID entry SHALL be valid only in RUN/STALL states.
REQ-027 stall_count_o SHALL increment by 1 on each edge whose cycle asserted a stall (REQ-018), SHALL saturate at all-ones, and SHALL not increment on redirect cycles.

Reset
REQ-028 On reset=0, the module SHALL immediately (asynchronously) set state=RUN, clear all scoreboard valid bits, and set stall_count_o=0.
REQ-029 Output values during and after reset SHALL be: pc_write=1, if_id_write=1, flushes=0, state_o=0.
REQ-030 A reset mid-stall or mid-flush SHALL abandon the operation, and no pending hazard SHALL survive reset.

Structure
REQ-031 The state encodings (RUN/STALL/FLUSH) and the scoreboard entry width SHALL live in the shared package riscv_pipe_pkg.
REQ-032 The scoreboard SHALL be the sub-module hazard_scoreboard, which owns the three entries, the shift/kill logic and the match outputs; the FSM and counter SHALL remain in hazard_sequencer.
REQ-033 The module SHALL be instantiated beside the pipe registers, with flush outputs ORed into each pipe register's clear and pc_write gating PC_Register.

Verification
REQ-034 Verification SHALL cover "addi x5,x0,7" followed by "add x6,x5,x5", which SHALL give 3 stall cycles, state sequence RUN,STALL,STALL,STALL,RUN, stall_count_o=3, and x6=14.
REQ-035 Verification SHALL cover a producer writing x5, one independent instruction, then a consumer of x5, which SHALL give exactly 2 stall cycles.
REQ-036 Verification SHALL cover a consumer reading only x0 after "addi x0,x0,1", which SHALL give no stall, with state remaining RUN.
REQ-037 Verification SHALL cover a taken beq, which SHALL give mem_redirect_i=1 with all three flushes=1 for one cycle, then state FLUSH for one cycle, then RUN; no wrong-path register write may occur.
REQ-038 Verification SHALL cover a redirect while in STALL, which SHALL give flush outputs with pc_write=1, a scoreboard EX/MEM cleared, and no stall_count_o increment for that cycle.
REQ-039 Verification SHALL cover reset=0 asserted mid-STALL, which SHALL give state_o=0, stall_count_o=0 and pc_write=1 before the next clock edge, with no stall after release.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types: sequencer state encodings and the hazard scoreboard entry.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package riscv_pipe_pkg;

   localparam int REG_ADDR_W = 5;

   // Encoding 2'd3 is never produced; the sequencer treats it as RUN.
   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } seq_state_t;

   // One in-flight instruction as seen by the hazard logic.
   typedef struct packed {
      logic                  vld;
      logic [REG_ADDR_W-1:0] rd;
      logic                  reg_write;
   } sb_entry_t;

   localparam int SB_ENTRY_W = $bits(sb_entry_t);

   // Scoreboard slot indices, mirroring ID/EX, EX/MEM and MEM/WB.
   localparam int SB_EX    = 0;
   localparam int SB_MEM   = 1;
   localparam int SB_WB    = 2;
   localparam int SB_DEPTH = 3;

   // True when a used, non-x0 source reads the register this entry will write.
   function automatic logic sb_hit(input sb_entry_t e,
                                   input logic [REG_ADDR_W-1:0] rs,
                                   input logic used);
      return used && (rs != '0) && e.vld && e.reg_write && (e.rd == rs);
   endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-entry destination scoreboard (EX, MEM, WB) with per-stage source match flags.
// Latency: entries shift one stage per clock; match outputs are combinational.
// Backpressure: a stall loads a bubble into EX; a redirect also kills the EX->MEM move.
//
// Ports:
//   clk, reset           clock, async active-low reset (clears every entry)
//   id_entry             destination info of the instruction in ID (vld=0 for a bubble)
//   stall, redirect      control from the sequencer for this cycle
//   rs1/rs2, *_used      sources of the ID instruction
//   match[SB_DEPTH-1:0]  per-stage hit against either used source
module hazard_scoreboard
   import riscv_pipe_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  sb_entry_t             id_entry,
   input  logic                  stall,
   input  logic                  redirect,
   input  logic [REG_ADDR_W-1:0] rs1,
   input  logic [REG_ADDR_W-1:0] rs2,
   input  logic                  rs1_used,
   input  logic                  rs2_used,
   output logic [SB_DEPTH-1:0]   match
);

   logic [SB_DEPTH-1:0][SB_ENTRY_W-1:0] sb_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sb_q <= '0;
      end else begin
         sb_q[SB_WB]  <= sb_q[SB_MEM];
         // The instruction leaving EX is on the wrong path when MEM redirects.
         sb_q[SB_MEM] <= redirect ? '0 : sb_q[SB_EX];
         sb_q[SB_EX]  <= (stall || redirect) ? '0 : id_entry;
      end
   end

   always_comb begin
      match = '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
         match[i] = sb_hit(sb_entry_t'(sb_q[i]), rs1, rs1_used) |
                    sb_hit(sb_entry_t'(sb_q[i]), rs2, rs2_used);
      end
   end

endmodule

// File: rtl/hazard_sequencer.sv
// Interlock sequencer for a 5-stage pipe without forwarding: stalls RAW hazards, flushes on MEM redirect.
// Latency: control outputs respond combinationally in the same cycle; state/counter update on the clock.
// Backpressure: a hazard holds PC and IF/ID and injects an ID/EX bubble; a redirect overrides and flushes.
//
// Ports:
//   clk, reset                       clock, async active-low reset
//   id_rs1_i/id_rs2_i, *_used_i      sources of the instruction in ID
//   id_rd_i, id_reg_write_i          destination of the instruction in ID
//   mem_redirect_i                   taken branch/jalr in MEM selects the PC target
//   pc_write_o, if_id_write_o        load enables for PC_Register and IF/ID
//   if_id/id_ex/ex_mem_flush_o       ORed into each pipe register's clear
//   state_o, stall_count_o           current state, saturating count of stall cycles
module hazard_sequencer
   import riscv_pipe_pkg::*;
#(
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [4:0]             id_rs1_i,
   input  logic [4:0]             id_rs2_i,
   input  logic                   id_rs1_used_i,
   input  logic                   id_rs2_used_i,
   input  logic [4:0]             id_rd_i,
   input  logic                   id_reg_write_i,
   input  logic                   mem_redirect_i,
   output logic                   pc_write_o,
   output logic                   if_id_write_o,
   output logic                   if_id_flush_o,
   output logic                   id_ex_flush_o,
   output logic                   ex_mem_flush_o,
   output logic [1:0]             state_o,
   output logic [STALL_CNT_W-1:0] stall_count_o
);

   seq_state_t             state_q;
   logic [STALL_CNT_W-1:0] cnt_q;
   sb_entry_t              id_entry;
   logic [SB_DEPTH-1:0]    match;
   logic                   id_vld;
   logic                   redirect;
   logic                   hazard;
   logic                   stall;

   // In FLUSH the ID register holds a bubble, so it can neither hazard nor enter the scoreboard.
   assign id_vld = (state_q == ST_RUN) || (state_q == ST_STALL);

   always_comb begin
      id_entry           = '0;
      id_entry.vld       = id_vld;
      id_entry.rd        = id_rd_i;
      id_entry.reg_write = id_reg_write_i;
   end

   hazard_scoreboard u_scoreboard (
      .clk      (clk),
      .reset    (reset),
      .id_entry (id_entry),
      .stall    (stall),
      .redirect (redirect),
      .rs1      (id_rs1_i),
      .rs2      (id_rs2_i),
      .rs1_used (id_rs1_used_i),
      .rs2_used (id_rs2_used_i),
      .match    (match)
   );

   // Held low while in reset so the pipe sees plain RUN controls until release.
   assign redirect = mem_redirect_i & reset;
   assign hazard   = id_vld & (|match);
   // A redirect discards the stalled instruction anyway, so it wins over the hazard.
   assign stall    = hazard & ~redirect;

   assign pc_write_o     = ~stall;
   assign if_id_write_o  = ~stall;
   assign if_id_flush_o  = redirect;
   assign id_ex_flush_o  = redirect | stall;
   assign ex_mem_flush_o = redirect;
   assign state_o        = state_q;
   assign stall_count_o  = cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
      end else begin
         // Next state depends only on this cycle's decision, so the unused encoding also lands in RUN.
         if (redirect) begin
            state_q <= ST_FLUSH;
         end else if (stall) begin
            state_q <= ST_STALL;
         end else begin
            state_q <= ST_RUN;
         end
         if (stall && (cnt_q != '1)) begin
            cnt_q <= cnt_q + STALL_CNT_W'(1);
         end
      end
   end

endmodule
